pimt_operand_issuer: RTL and testbench
======================================

Name: pimt_operand_issuer

Overview:
- Transmit side of the pimt_3 operand interface.
- Buffers two independent upstream operand streams:
  - the powsub4/alpha_i pair;
  - phi_rr.
- Launches matched entries to pimt_3 with powsub4_vld and phi_rr_vld asserted on the same cycle, so pimt_3's internal multiplier outputs stay aligned.
- Bounds work in flight with a credit counter returned by pimt3_result_vld, and keeps issue/return statistics.

Parameters:
- DEPTH, 4, entries per input FIFO; power of two, at least 2.
- MAX_INFLIGHT, 8, maximum operand sets issued but not yet returned as pimt3_result_vld; range 1..255.
- CNT_W, 16, width of the issued/returned statistics counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pa_valid  input  1  upstream powsub4/alpha_i pair valid.
- pa_ready  output  1  pair FIFO not full.
- pa_powsub4  input  64  IEEE-754 double.
- pa_alpha_i  input  64  IEEE-754 double.
- ph_valid  input  1  upstream phi_rr valid.
- ph_ready  output  1  phi FIFO not full.
- ph_phi_rr  input  64  IEEE-754 double.
- powsub4  output  64  to pimt_3.
- powsub4_vld  output  1  to pimt_3.
- alpha_i  output  64  to pimt_3.
- phi_rr  output  64  to pimt_3.
- phi_rr_vld  output  1  to pimt_3.
- pimt3_result_vld  input  1  result return from pimt_3; frees one credit.
- inflight  output  8  current outstanding count.
- issued_cnt  output  CNT_W  total issues, wraps.
- returned_cnt  output  CNT_W  total returns, wraps.
- err_underflow  output  1  sticky: a return arrived with inflight==0.
- idle  output  1  both FIFOs empty and inflight==0.

Behaviour:
- Reset, asynchronous and active-low, clears:
  - both FIFOs (empty);
  - all counters to 0;
  - powsub4/alpha_i/phi_rr to 64'h0;
  - both vld outputs to 0;
  - err_underflow to 0.
  - After reset: idle=1, pa_ready=ph_ready=1.
- Upstream handshake:
  - An entry is written on pa_valid & pa_ready (or ph_valid & ph_ready).
  - ready = !full, registered from the FIFO count; no combinational path from valid to ready.
  - Writing while full is impossible because ready=0.
- Issue condition, evaluated each cycle:
  - fire = pair_nonempty & phi_nonempty & (inflight < MAX_INFLIGHT | pimt3_result_vld).
- Issue timing:
  - On fire, both FIFOs pop their head, and the data moves into the output registers on that clock edge.
  - powsub4_vld and phi_rr_vld are 1 in the next cycle only: a single-cycle pulse per issue, always identical.
  - Output data holds its last value when vld=0.
  - Latency from a write into an empty FIFO to vld high is 2 cycles: write edge, then issue edge.
  - Throughput is one issue per cycle when credits allow.
- pimt_3 has no backpressure; its multiplier tready is assumed high. Throttling is by credits only.
- Credits:
  - Next inflight = inflight + fire − pimt3_result_vld.
  - A simultaneous fire and return at inflight==MAX_INFLIGHT is allowed; inflight stays at MAX.
  - A return with inflight==0 and no fire sets err_underflow (sticky until reset), and inflight stays 0.
  - A return with inflight==0 and a same-cycle fire nets inflight to 0, with no error.
- Counters:
  - issued_cnt increments on fire.
  - returned_cnt increments on every pimt3_result_vld.
  - Both wrap modulo 2^CNT_W.
- FIFO behaviour:
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop on a full FIFO is allowed: the count is unchanged, and ready stays 0 that cycle (registered).
  - A simultaneous push and pop on an empty FIFO is not a bypass: the new entry is issued at the earliest on the next cycle.
- Stream mismatch: a surplus entry in either stream waits indefinitely for its partner; there is no timeout.
- Reset mid-operation:
  - Buffered and in-flight entries are discarded, and counters are cleared.
  - Results returning after reset count as underflow errors; the system must quiesce pimt_3 before asserting reset.

Decomposition:
- Shared package pimt_pkg holds:
  - FP_W=64;
  - FP_NEG_ONE=64'hBFF0000000000000;
  - FP_ONE=64'h3FF0000000000000;
  - FP_ZERO;
  - the typedef for the pair struct {powsub4, alpha_i}.
- Sub-module pimt_sync_fifo (parameters WIDTH, DEPTH) with a registered full/empty/count. It is instantiated twice: WIDTH=128 for the pair, WIDTH=64 for phi_rr.

Test Plan:
- Single set:
  - Stimulus: write pair (0x4000000000000000, 0x3FF8000000000000) and phi 0x4008000000000000 in the same cycle.
  - Response: vld pulses exactly once, 2 cycles later, with those values; inflight=1; returning result_vld gives inflight=0 and idle=1.
- Skewed streams:
  - Stimulus: push 3 pairs, then push 3 phi_rr 10 cycles later.
  - Response: no vld before the first phi write; then 3 back-to-back pulses in FIFO order; issued_cnt=3.
- Credit limit:
  - Stimulus: MAX_INFLIGHT=8 with 12 sets buffered and no returns.
  - Response: exactly 8 pulses then a stall.
  - Stimulus: one result_vld.
  - Response: one more issue; with fire and return in the same cycle at inflight=8, inflight stays 8.
- Full FIFO:
  - Stimulus: push DEPTH=4 pairs with no phi.
  - Response: pa_ready=0 after the 4th write; a 5th valid is held, not written.
  - Stimulus: one phi push.
  - Response: pa_ready returns to 1 one cycle after the pop.
- Underflow:
  - Stimulus: result_vld pulse from reset with no issue.
  - Response: err_underflow=1 and stays 1; inflight=0; returned_cnt=1.
- Reset mid-run:
  - Stimulus: assert rst_n=0 asynchronously with 3 entries buffered and inflight=5.
  - Response: immediately, vld=0 and all counters, FIFOs and data are 0; after release, no spurious vld.

Source files
------------

// File: rtl/pimt_pkg.sv
// Shared types and constants for the pimt_3 operand interface.
package pimt_pkg;

    localparam int FP_W = 64;

    localparam logic [FP_W-1:0] FP_NEG_ONE = 64'hBFF0000000000000;
    localparam logic [FP_W-1:0] FP_ONE     = 64'h3FF0000000000000;
    localparam logic [FP_W-1:0] FP_ZERO    = 64'h0000000000000000;

    typedef struct packed {
        logic [FP_W-1:0] powsub4;
        logic [FP_W-1:0] alpha_i;
    } pa_pair_t;

endpackage

// File: rtl/pimt_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count; head data is read combinationally.
module pimt_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the same cycle frees a slot.
    always_comb begin
        do_pop   = pop & ~empty_q;
        do_push  = push & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/pimt_operand_issuer.sv
// Transmit side of the pimt_3 operand interface: pairs two operand streams and
// issues matched sets under a credit limit refilled by pimt3_result_vld.
module pimt_operand_issuer
    import pimt_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pa_valid,
    output logic             pa_ready,
    input  logic [FP_W-1:0]  pa_powsub4,
    input  logic [FP_W-1:0]  pa_alpha_i,
    input  logic             ph_valid,
    output logic             ph_ready,
    input  logic [FP_W-1:0]  ph_phi_rr,
    output logic [FP_W-1:0]  powsub4,
    output logic             powsub4_vld,
    output logic [FP_W-1:0]  alpha_i,
    output logic [FP_W-1:0]  phi_rr,
    output logic             phi_rr_vld,
    input  logic             pimt3_result_vld,
    output logic [7:0]       inflight,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] returned_cnt,
    output logic             err_underflow,
    output logic             idle
);
    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [7:0] MAX_INFL = 8'(MAX_INFLIGHT);

    pa_pair_t        pa_wdata, pa_head;
    logic [FP_W-1:0] ph_head;
    logic            pa_full, pa_empty, ph_full, ph_empty;
    logic [CW-1:0]   pa_count, ph_count;
    logic            pa_push, ph_push, fire;

    logic [FP_W-1:0]  powsub4_q, powsub4_d;
    logic [FP_W-1:0]  alpha_i_q, alpha_i_d;
    logic [FP_W-1:0]  phi_rr_q, phi_rr_d;
    logic             vld_q, vld_d;
    logic [7:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] returned_q, returned_d;
    logic             err_q, err_d;

    assign pa_wdata = '{powsub4: pa_powsub4, alpha_i: pa_alpha_i};
    assign pa_push  = pa_valid & pa_ready;
    assign ph_push  = ph_valid & ph_ready;

    pimt_sync_fifo #(.WIDTH($bits(pa_pair_t)), .DEPTH(DEPTH)) u_pa_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pa_push),
        .wdata (pa_wdata),
        .pop   (fire),
        .rdata (pa_head),
        .full  (pa_full),
        .empty (pa_empty),
        .count (pa_count)
    );

    pimt_sync_fifo #(.WIDTH(FP_W), .DEPTH(DEPTH)) u_ph_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ph_push),
        .wdata (ph_phi_rr),
        .pop   (fire),
        .rdata (ph_head),
        .full  (ph_full),
        .empty (ph_empty),
        .count (ph_count)
    );

    // A return in the same cycle frees the credit that this issue consumes.
    always_comb begin
        fire       = ~pa_empty & ~ph_empty & ((inflight_q < MAX_INFL) | pimt3_result_vld);
        inflight_d = inflight_q;
        err_d      = err_q;
        unique case ({fire, pimt3_result_vld})
            2'b10: inflight_d = inflight_q + 8'd1;
            2'b01: begin
                if (inflight_q == '0) err_d = 1'b1;
                else                  inflight_d = inflight_q - 8'd1;
            end
            default: ;
        endcase
        issued_d   = issued_q + CNT_W'(fire);
        returned_d = returned_q + CNT_W'(pimt3_result_vld);
        vld_d      = fire;
        powsub4_d  = fire ? pa_head.powsub4 : powsub4_q;
        alpha_i_d  = fire ? pa_head.alpha_i : alpha_i_q;
        phi_rr_d   = fire ? ph_head         : phi_rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            powsub4_q  <= FP_ZERO;
            alpha_i_q  <= FP_ZERO;
            phi_rr_q   <= FP_ZERO;
            vld_q      <= 1'b0;
            inflight_q <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            err_q      <= 1'b0;
        end else begin
            powsub4_q  <= powsub4_d;
            alpha_i_q  <= alpha_i_d;
            phi_rr_q   <= phi_rr_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            err_q      <= err_d;
        end
    end

    // One flop drives both valids so they can never disagree.
    assign powsub4_vld   = vld_q;
    assign phi_rr_vld    = vld_q;
    assign powsub4       = powsub4_q;
    assign alpha_i       = alpha_i_q;
    assign phi_rr        = phi_rr_q;
    assign pa_ready      = ~pa_full;
    assign ph_ready      = ~ph_full;
    assign inflight      = inflight_q;
    assign issued_cnt    = issued_q;
    assign returned_cnt  = returned_q;
    assign err_underflow = err_q;
    assign idle          = (pa_count == '0) & (ph_count == '0) & (inflight_q == '0);

endmodule

// File: tb/tb_pimt_operand_issuer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pimt_operand_issuer;
    localparam int DEPTH        = 4;
    localparam int MAX_INFLIGHT = 8;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pa_valid, pa_ready, ph_valid, ph_ready;
    logic [63:0]      pa_powsub4, pa_alpha_i, ph_phi_rr;
    logic [63:0]      powsub4, alpha_i, phi_rr;
    logic             powsub4_vld, phi_rr_vld, pimt3_result_vld;
    logic [7:0]       inflight;
    logic [CNT_W-1:0] issued_cnt, returned_cnt;
    logic             err_underflow, idle;

    pimt_operand_issuer #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pa_valid         (pa_valid),
        .pa_ready         (pa_ready),
        .pa_powsub4       (pa_powsub4),
        .pa_alpha_i       (pa_alpha_i),
        .ph_valid         (ph_valid),
        .ph_ready         (ph_ready),
        .ph_phi_rr        (ph_phi_rr),
        .powsub4          (powsub4),
        .powsub4_vld      (powsub4_vld),
        .alpha_i          (alpha_i),
        .phi_rr           (phi_rr),
        .phi_rr_vld       (phi_rr_vld),
        .pimt3_result_vld (pimt3_result_vld),
        .inflight         (inflight),
        .issued_cnt       (issued_cnt),
        .returned_cnt     (returned_cnt),
        .err_underflow    (err_underflow),
        .idle             (idle)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: buffered entries as queues, credits as a plain integer.
    logic [127:0]     m_pa [$];
    logic [63:0]      m_ph [$];
    int               m_infl;
    logic [CNT_W-1:0] m_iss, m_ret;
    bit               m_err, m_vld;
    logic [63:0]      m_pow, m_alp, m_phi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pa.delete();
        m_ph.delete();
        m_infl = 0;
        m_iss  = '0;
        m_ret  = '0;
        m_err  = 1'b0;
        m_vld  = 1'b0;
        m_pow  = '0;
        m_alp  = '0;
        m_phi  = '0;
    endtask

    task automatic check_all();
        check("pa_ready",      64'(pa_ready),      64'(m_pa.size() < DEPTH));
        check("ph_ready",      64'(ph_ready),      64'(m_ph.size() < DEPTH));
        check("powsub4_vld",   64'(powsub4_vld),   64'(m_vld));
        check("phi_rr_vld",    64'(phi_rr_vld),    64'(m_vld));
        check("powsub4",       powsub4,            m_pow);
        check("alpha_i",       alpha_i,            m_alp);
        check("phi_rr",        phi_rr,             m_phi);
        check("inflight",      64'(inflight),      64'(m_infl));
        check("issued_cnt",    64'(issued_cnt),    64'(m_iss));
        check("returned_cnt",  64'(returned_cnt),  64'(m_ret));
        check("err_underflow", 64'(err_underflow), 64'(m_err));
        check("idle",          64'(idle),
              64'(m_pa.size() == 0 && m_ph.size() == 0 && m_infl == 0));
    endtask

    // Called just after a falling edge: check, drive, advance the model, run one clock.
    task automatic cycle(input bit pv, input logic [63:0] pp, input logic [63:0] pa,
                         input bit hv, input logic [63:0] ph, input bit rv);
        bit           pa_rdy, ph_rdy, fire;
        int           n;
        logic [127:0] pr;
        check_all();
        pa_valid         = pv;
        pa_powsub4       = pp;
        pa_alpha_i       = pa;
        ph_valid         = hv;
        ph_phi_rr        = ph;
        pimt3_result_vld = rv;
        pa_rdy = m_pa.size() < DEPTH;
        ph_rdy = m_ph.size() < DEPTH;
        fire   = m_pa.size() > 0 && m_ph.size() > 0 && (m_infl < MAX_INFLIGHT || rv);
        if (fire) begin
            pr    = m_pa.pop_front();
            m_pow = pr[127:64];
            m_alp = pr[63:0];
            m_phi = m_ph.pop_front();
            m_iss = m_iss + 1'b1;
        end
        m_vld = fire;
        if (pv && pa_rdy) m_pa.push_back({pp, pa});
        if (hv && ph_rdy) m_ph.push_back(ph);
        if (rv) m_ret = m_ret + 1'b1;
        n = m_infl + int'(fire) - int'(rv);
        if (n < 0) begin
            n     = 0;
            m_err = 1'b1;
        end
        m_infl = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input bit rv);
        cycle(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, rv);
    endtask

    // Asynchronous reset asserted while the clock is low, released on a falling edge.
    task automatic do_reset();
        #2;
        rst_n            = 1'b0;
        pa_valid         = 1'b0;
        ph_valid         = 1'b0;
        pimt3_result_vld = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        pa_valid         = 1'b0;
        ph_valid         = 1'b0;
        pimt3_result_vld = 1'b0;
        pa_powsub4       = '0;
        pa_alpha_i       = '0;
        ph_phi_rr        = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single set: vld two edges after the write.
        cycle(1'b1, 64'h4000000000000000, 64'h3FF8000000000000, 1'b1, 64'h4008000000000000, 1'b0);
        check("single_early_vld", 64'(powsub4_vld), 64'd0);
        idle_cycle(1'b0);
        check("single_vld", 64'(powsub4_vld), 64'd1);
        check("single_pow", powsub4, 64'h4000000000000000);
        check("single_phi", phi_rr, 64'h4008000000000000);
        check("single_infl", 64'(inflight), 64'd1);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        check("single_idle", 64'(idle), 64'd1);

        // Skewed streams: pairs wait for their phi partners.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle_cycle(1'b0);
            check("skew_no_vld", 64'(powsub4_vld), 64'd0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 64'h0, 1'b1, 64'h3000 + 64'(i), 1'b0);
        idle_cycle(1'b0);
        check("skew_issued", 64'(issued_cnt), 64'd4);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);

        // Credit limit: 8 issues, stall, then one return admits exactly one more.
        for (int i = 0; i < 20; i++) cycle(1'b1, 64'h5000 + 64'(i), 64'h6000 + 64'(i), 1'b1, 64'h7000 + 64'(i), 1'b0);
        check("credit_issued", 64'(issued_cnt), 64'd12);
        check("credit_infl", 64'(inflight), 64'd8);
        idle_cycle(1'b1);
        check("credit_fire_ret_infl", 64'(inflight), 64'd8);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        check("credit_stall_issued", 64'(issued_cnt), 64'd13);
        for (int i = 0; i < 40; i++) idle_cycle(m_infl != 0);
        check("credit_drained_idle", 64'(idle), 64'd1);

        // Full pair FIFO: fifth valid is held off until a phi push frees a slot.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'h8000 + 64'(i), 64'h9000 + 64'(i), 1'b0, 64'h0, 1'b0);
        check("full_ready_low", 64'(pa_ready), 64'd0);
        cycle(1'b1, 64'hDEAD, 64'hBEEF, 1'b0, 64'h0, 1'b0);
        cycle(1'b0, 64'h0, 64'h0, 1'b1, 64'hA000, 1'b0);
        check("full_ready_still_low", 64'(pa_ready), 64'd0);
        idle_cycle(1'b0);
        check("full_ready_back", 64'(pa_ready), 64'd1);
        for (int i = 1; i < DEPTH; i++) cycle(1'b0, 64'h0, 64'h0, 1'b1, 64'hA000 + 64'(i), 1'b0);
        for (int i = 0; i < 10; i++) idle_cycle(m_infl != 0);

        // Underflow: a return with nothing outstanding.
        do_reset();
        idle_cycle(1'b1);
        check("uf_err", 64'(err_underflow), 64'd1);
        check("uf_ret", 64'(returned_cnt), 64'd1);
        check("uf_infl", 64'(inflight), 64'd0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        check("uf_sticky", 64'(err_underflow), 64'd1);

        // Reset mid-run with entries buffered and five outstanding.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'hB000 + 64'(i), 64'hC000 + 64'(i), 1'b1, 64'hD000 + 64'(i), 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("mid_infl5", 64'(inflight), 64'd5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hE000 + 64'(i), 64'hF000 + 64'(i), 1'b0, 64'h0, 1'b0);
        do_reset();
        check("mid_rst_pow", powsub4, 64'd0);
        check("mid_rst_issued", 64'(issued_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            idle_cycle(1'b0);
            check("mid_no_spurious_vld", 64'(powsub4_vld), 64'd0);
        end

        // Random traffic with independent stream rates and returns.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, {$urandom, $urandom},
                  m_infl != 0 && $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 30; i++) idle_cycle(m_infl != 0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
